// File: rtl/mem_arb_sram.sv
// Shared byte-addressed SRAM with round-robin arbitration over several requesters,
// address-range error reporting and a fixed-latency, in-order response pipeline.
module mem_arb_sram #(
    parameter int unsigned          NumPorts    = 2,
    parameter int unsigned          NumWords    = 1 << 17,
    parameter int unsigned          AddrWidth   = 64,
    parameter int unsigned          DataWidth   = 64,
    parameter int unsigned          ReadLatency = 1,
    parameter logic [AddrWidth-1:0] BaseAddr    = '0,
    parameter int unsigned          StrbWidth   = DataWidth / 8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NumPorts-1:0]            req_i,
    output logic [NumPorts-1:0]            gnt_o,
    input  logic [NumPorts*AddrWidth-1:0]  addr_i,
    input  logic [NumPorts-1:0]            we_i,
    input  logic [NumPorts*DataWidth-1:0]  wdata_i,
    input  logic [NumPorts*StrbWidth-1:0]  strb_i,
    output logic [NumPorts-1:0]            rvalid_o,
    output logic [NumPorts*DataWidth-1:0]  rdata_o,
    output logic [NumPorts-1:0]            rerr_o
);

    localparam int unsigned PortW     = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned IdxW      = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int unsigned ByteShift = $clog2(StrbWidth);
    localparam int unsigned Last      = ReadLatency - 1;
    localparam logic [AddrWidth-1:0] Limit = AddrWidth'(64'(NumWords) * 64'(StrbWidth));

    logic [PortW-1:0]     ptr_q;
    logic [PortW-1:0]     ptr_d;
    logic [PortW-1:0]     gnt_idx;
    logic                 gnt_valid;

    logic [AddrWidth-1:0] sel_addr;
    logic [AddrWidth-1:0] offset;
    logic                 sel_we;
    logic [DataWidth-1:0] sel_wdata;
    logic [StrbWidth-1:0] sel_strb;
    logic                 addr_err;
    logic [IdxW-1:0]      word_idx;
    logic [DataWidth-1:0] rd_word;

    logic [DataWidth-1:0] mem_q [NumWords];

    logic                 pipe_valid_q [ReadLatency];
    logic [PortW-1:0]     pipe_port_q  [ReadLatency];
    logic                 pipe_err_q   [ReadLatency];
    logic [DataWidth-1:0] pipe_data_q  [ReadLatency];

    // Priority pointer register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Round-robin search starting at the pointer; pointer advances past the winner
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        ptr_d     = ptr_q;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            if (!gnt_valid && req_i[(32'(ptr_q) + i) % NumPorts]) begin
                gnt_valid = 1'b1;
                gnt_idx   = PortW'((32'(ptr_q) + i) % NumPorts);
            end
        end
        gnt_valid = gnt_valid && rst_ni;
        if (gnt_valid) begin
            ptr_d = (gnt_idx == PortW'(NumPorts - 1)) ? '0 : gnt_idx + PortW'(1);
        end
    end

    // Grant is combinational so a request can be accepted in the cycle it appears
    always_comb begin
        gnt_o = '0;
        if (gnt_valid) begin
            gnt_o[gnt_idx] = 1'b1;
        end
    end

    // Winner's payload and address decode; underflow wraps to a huge offset
    always_comb begin
        sel_addr  = addr_i[32'(gnt_idx) * AddrWidth +: AddrWidth];
        sel_we    = we_i[gnt_idx];
        sel_wdata = wdata_i[32'(gnt_idx) * DataWidth +: DataWidth];
        sel_strb  = strb_i[32'(gnt_idx) * StrbWidth +: StrbWidth];
        offset    = sel_addr - BaseAddr;
        addr_err  = (offset >= Limit);
        word_idx  = IdxW'(offset >> ByteShift);
        rd_word   = '0;
        if (gnt_valid && !sel_we && !addr_err) begin
            rd_word = mem_q[word_idx];
        end
    end

    // Storage array, byte-masked writes, never reset
    always_ff @(posedge clk_i) begin
        if (gnt_valid && sel_we && !addr_err) begin
            for (int unsigned b = 0; b < StrbWidth; b++) begin
                if (sel_strb[b]) begin
                    mem_q[word_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Response control shift register; reset drops everything in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < ReadLatency; i++) begin
                pipe_valid_q[i] <= 1'b0;
                pipe_port_q[i]  <= '0;
                pipe_err_q[i]   <= 1'b0;
            end
        end else begin
            pipe_valid_q[0] <= gnt_valid;
            pipe_port_q[0]  <= gnt_idx;
            pipe_err_q[0]   <= gnt_valid && addr_err;
            for (int unsigned i = 1; i < ReadLatency; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_port_q[i]  <= pipe_port_q[i-1];
                pipe_err_q[i]   <= pipe_err_q[i-1];
            end
        end
    end

    // Response data shift register; qualified by the valid bit at the output
    always_ff @(posedge clk_i) begin
        pipe_data_q[0] <= rd_word;
        for (int unsigned i = 1; i < ReadLatency; i++) begin
            pipe_data_q[i] <= pipe_data_q[i-1];
        end
    end

    // Steer the last stage onto its port; all response outputs idle at zero
    always_comb begin
        rvalid_o = '0;
        rerr_o   = '0;
        rdata_o  = '0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            if (pipe_valid_q[Last] && (pipe_port_q[Last] == PortW'(p))) begin
                rvalid_o[p]                         = 1'b1;
                rerr_o[p]                           = pipe_err_q[Last];
                rdata_o[p*DataWidth +: DataWidth]   = pipe_data_q[Last];
            end
        end
    end

endmodule

// File: tb/tb_mem_arb_sram.sv
// Bench for mem_arb_sram: arbitration table, directed multi-cycle sequences and
// randomized traffic checked against a transaction-level memory/arbiter model.
module tb_mem_arb_sram;

    localparam int          NP   = 4;
    localparam int          NW   = 1024;
    localparam int          L    = 3;
    localparam logic [63:0] BASE = 64'h8000_0000;

    logic            clk;
    logic            rst_n;
    logic [NP-1:0]   req;
    logic [NP-1:0]   gnt;
    logic [NP*64-1:0] addr;
    logic [NP-1:0]   we;
    logic [NP*64-1:0] wdata;
    logic [NP*8-1:0] strb;
    logic [NP-1:0]   rvalid;
    logic [NP*64-1:0] rdata;
    logic [NP-1:0]   rerr;

    mem_arb_sram #(
        .NumPorts(NP), .NumWords(NW), .AddrWidth(64), .DataWidth(64),
        .ReadLatency(L), .BaseAddr(BASE)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr),
        .we_i(we), .wdata_i(wdata), .strb_i(strb), .rvalid_o(rvalid),
        .rdata_o(rdata), .rerr_o(rerr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          port;
        bit          err;
        logic [63:0] data;
        logic [63:0] mask;
    } resp_t;

    typedef struct {
        logic [NP-1:0] req;
        logic [NP-1:0] gnt;
    } vec_t;

    // Requester-side state
    logic [NP-1:0] p_req;
    logic          p_we    [NP];
    logic [63:0]   p_addr  [NP];
    logic [63:0]   p_wdata [NP];
    logic [7:0]    p_strb  [NP];

    // Reference model: plain word array with per-byte written flags, pointer, response list
    logic [63:0] mmem   [NW];
    logic [7:0]  mknown [NW];
    int          mptr;
    resp_t       exp_q[$];
    int          cyc;

    int            tests;
    int            fails;
    logic [63:0]   last_rdata [NP];
    logic          last_rerr  [NP];
    int            resp_cnt   [NP];
    logic [NP-1:0] last_gnt;
    int            gp;
    vec_t          tbl [14];

    task automatic check(input bit ok, input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            req[p]          = p_req[p];
            we[p]           = p_we[p];
            addr[p*64 +: 64]  = p_addr[p];
            wdata[p*64 +: 64] = p_wdata[p];
            strb[p*8 +: 8]    = p_strb[p];
        end
    endtask

    // One clock cycle: check outputs against the model, then advance the model
    task automatic tick(output int g);
        logic [NP-1:0] ev;
        logic [63:0]   ed [NP];
        logic [63:0]   em [NP];
        bit            ee [NP];
        logic [63:0]   off;
        logic [63:0]   act;
        int            idx;
        int            c;
        resp_t         r;
        drive();
        #1;
        ev = '0;
        for (int p = 0; p < NP; p++) begin
            ed[p] = '0; em[p] = '1; ee[p] = 1'b0;
        end
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            r = exp_q.pop_front();
            if (r.due == cyc) begin
                ev[r.port] = 1'b1; ed[r.port] = r.data; em[r.port] = r.mask; ee[r.port] = r.err;
            end
        end
        check(rvalid == ev, "rvalid", 64'(rvalid), 64'(ev));
        for (int p = 0; p < NP; p++) begin
            act = rdata[p*64 +: 64];
            check(rerr[p] == ee[p], "rerr", 64'(rerr[p]), 64'(ee[p]));
            check(((act ^ ed[p]) & em[p]) == 64'h0, "rdata", act, ed[p]);
            if (rvalid[p]) begin
                last_rdata[p] = act; last_rerr[p] = rerr[p]; resp_cnt[p]++;
            end
        end
        g = -1;
        for (int k = 0; k < NP; k++) begin
            c = (mptr + k) % NP;
            if (g < 0 && p_req[c]) g = c;
        end
        check(gnt == ((g < 0) ? 4'b0 : 4'(1 << g)), "gnt", 64'(gnt),
              (g < 0) ? 64'h0 : 64'(1 << g));
        last_gnt = gnt;
        if (g >= 0) begin
            off = p_addr[g] - BASE;
            r.due = cyc + L; r.port = g; r.err = 1'b0; r.data = '0; r.mask = '1;
            if (off >= 64'(NW * 8)) begin
                r.err = 1'b1;
            end else begin
                idx = int'(off >> 3);
                if (p_we[g]) begin
                    for (int b = 0; b < 8; b++) begin
                        if (p_strb[g][b]) begin
                            mmem[idx][b*8 +: 8] = p_wdata[g][b*8 +: 8];
                            mknown[idx][b] = 1'b1;
                        end
                    end
                end else begin
                    r.data = mmem[idx];
                    for (int b = 0; b < 8; b++) r.mask[b*8 +: 8] = {8{mknown[idx][b]}};
                end
            end
            exp_q.push_back(r);
            mptr = (g + 1) % NP;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        int g;
        p_req = '0;
        for (int i = 0; i < L + 1; i++) tick(g);
    endtask

    // Single transaction on one port; bounded wait for its grant
    task automatic one(input int p, input bit w, input logic [63:0] a,
                       input logic [63:0] d, input logic [7:0] s);
        int g;
        bit done;
        done = 1'b0;
        p_req = '0;
        p_req[p] = 1'b1; p_we[p] = w; p_addr[p] = a; p_wdata[p] = d; p_strb[p] = s;
        for (int i = 0; i < 8 && !done; i++) begin
            tick(g);
            if (g == p) done = 1'b1;
        end
        p_req[p] = 1'b0;
        check(done, "grant_timeout", 64'(done), 64'h1);
    endtask

    // Reset pulse of one cycle with every port requesting
    task automatic do_reset();
        for (int p = 0; p < NP; p++) begin
            p_req[p] = 1'b1; p_we[p] = 1'b0; p_addr[p] = BASE;
        end
        drive();
        rst_n = 1'b0;
        #1;
        check(gnt == '0, "rst_gnt", 64'(gnt), 64'h0);
        check(rvalid == '0, "rst_rvalid", 64'(rvalid), 64'h0);
        check(rerr == '0, "rst_rerr", 64'(rerr), 64'h0);
        check(rdata == '0, "rst_rdata", rdata[63:0], 64'h0);
        exp_q.delete();
        mptr = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        p_req = '0;
        cyc++;
    endtask

    function automatic logic [63:0] rand_addr();
        int k;
        k = $urandom_range(0, 19);
        if (k < 16) return BASE + 64'(k * 8) + 64'($urandom_range(0, 7));
        if (k == 16) return BASE + 64'((NW - 1) * 8);
        if (k == 17) return BASE - 64'($urandom_range(1, 64));
        return BASE + 64'(NW * 8) + 64'($urandom_range(0, 4095));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          cnt0 [NP];
        logic [63:0] b2b_addr [NP];

        tests = 0; fails = 0; cyc = 0; mptr = 0;
        clk = 1'b0; rst_n = 1'b0;
        p_req = '0;
        for (int p = 0; p < NP; p++) begin
            p_we[p] = 1'b0; p_addr[p] = BASE; p_wdata[p] = '0; p_strb[p] = '0;
            last_rdata[p] = '0; last_rerr[p] = 1'b0; resp_cnt[p] = 0;
        end
        for (int i = 0; i < NW; i++) begin
            mmem[i] = '0; mknown[i] = '0;
        end

        tbl[0]  = '{4'b0011, 4'b0001};
        tbl[1]  = '{4'b0011, 4'b0010};
        tbl[2]  = '{4'b0011, 4'b0001};
        tbl[3]  = '{4'b0011, 4'b0010};
        tbl[4]  = '{4'b0011, 4'b0001};
        tbl[5]  = '{4'b0011, 4'b0010};
        tbl[6]  = '{4'b0010, 4'b0010};
        tbl[7]  = '{4'b0000, 4'b0000};
        tbl[8]  = '{4'b1111, 4'b0100};
        tbl[9]  = '{4'b1001, 4'b1000};
        tbl[10] = '{4'b1010, 4'b0010};
        tbl[11] = '{4'b1010, 4'b1000};
        tbl[12] = '{4'b0100, 4'b0100};
        tbl[13] = '{4'b0001, 4'b0001};

        drive();
        #3;
        check(gnt == '0, "init_gnt", 64'(gnt), 64'h0);
        check(rvalid == '0, "init_rvalid", 64'(rvalid), 64'h0);
        check(rdata == '0, "init_rdata", rdata[63:0], 64'h0);
        check(rerr == '0, "init_rerr", 64'(rerr), 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Write then read back
        one(0, 1'b1, BASE, 64'hDEADBEEF_CAFEF00D, 8'hFF);
        one(0, 1'b0, BASE, '0, 8'h00);
        drain();
        check(last_rdata[0] == 64'hDEADBEEF_CAFEF00D, "wr_rd_data", last_rdata[0],
              64'hDEADBEEF_CAFEF00D);
        check(last_rerr[0] == 1'b0, "wr_rd_err", 64'(last_rerr[0]), 64'h0);

        // Byte strobes
        one(0, 1'b1, BASE + 64'h8, 64'h11111111_11111111, 8'hFF);
        one(0, 1'b1, BASE + 64'h8, 64'hAAAAAAAA_AAAAAAAA, 8'h0F);
        one(0, 1'b0, BASE + 64'h8, '0, 8'h00);
        drain();
        check(last_rdata[0] == 64'h11111111_AAAAAAAA, "strb_data", last_rdata[0],
              64'h11111111_AAAAAAAA);

        // Out-of-range accesses on both sides of the window
        one(0, 1'b1, BASE + 64'((NW - 1) * 8), 64'h01234567_89ABCDEF, 8'hFF);
        one(1, 1'b0, 64'h7FFF_FFF8, '0, 8'h00);
        drain();
        check(last_rerr[1] == 1'b1 && last_rdata[1] == 64'h0, "err_below", last_rdata[1], 64'h0);
        one(1, 1'b0, BASE + 64'(NW * 8), '0, 8'h00);
        drain();
        check(last_rerr[1] == 1'b1 && last_rdata[1] == 64'h0, "err_above", last_rdata[1], 64'h0);
        one(1, 1'b1, BASE + 64'(NW * 8), 64'h55555555_55555555, 8'hFF);
        one(1, 1'b1, 64'h7FFF_FFF8, 64'h66666666_66666666, 8'hFF);
        one(1, 1'b0, BASE, '0, 8'h00);
        drain();
        check(last_rdata[1] == 64'hDEADBEEF_CAFEF00D, "err_nowrite_lo", last_rdata[1],
              64'hDEADBEEF_CAFEF00D);
        one(1, 1'b0, BASE + 64'((NW - 1) * 8), '0, 8'h00);
        drain();
        check(last_rdata[1] == 64'h01234567_89ABCDEF, "err_nowrite_hi", last_rdata[1],
              64'h01234567_89ABCDEF);

        // Arbitration table from a freshly reset pointer
        do_reset();
        for (int i = 0; i < 14; i++) begin
            for (int p = 0; p < NP; p++) begin
                p_req[p] = tbl[i].req[p]; p_we[p] = 1'b0; p_addr[p] = BASE + 64'(8 * p);
            end
            tick(gp);
            check(last_gnt == tbl[i].gnt, "tbl_gnt", 64'(last_gnt), 64'(tbl[i].gnt));
        end
        drain();

        // Four back-to-back reads from different ports
        b2b_addr[0] = BASE; b2b_addr[1] = BASE + 64'h8;
        b2b_addr[2] = BASE + 64'((NW - 1) * 8); b2b_addr[3] = BASE;
        for (int p = 0; p < NP; p++) begin
            p_req[p] = 1'b1; p_we[p] = 1'b0; p_addr[p] = b2b_addr[p]; cnt0[p] = resp_cnt[p];
        end
        n = 0;
        while (p_req != '0 && n < 8) begin
            tick(gp);
            if (gp >= 0) p_req[gp] = 1'b0;
            n++;
        end
        check(n == 4, "b2b_cycles", 64'(n), 64'h4);
        drain();
        for (int p = 0; p < NP; p++)
            check(resp_cnt[p] == cnt0[p] + 1, "b2b_count", 64'(resp_cnt[p]), 64'(cnt0[p] + 1));
        check(last_rdata[2] == 64'h01234567_89ABCDEF, "b2b_data", last_rdata[2],
              64'h01234567_89ABCDEF);

        // Reset with two reads in flight
        for (int p = 0; p < 2; p++) begin
            p_req[p] = 1'b1; p_we[p] = 1'b0; p_addr[p] = BASE;
        end
        for (int i = 0; i < 2; i++) begin
            tick(gp);
            if (gp >= 0) p_req[gp] = 1'b0;
        end
        for (int p = 0; p < NP; p++) cnt0[p] = resp_cnt[p];
        do_reset();
        drain();
        drain();
        for (int p = 0; p < NP; p++)
            check(resp_cnt[p] == cnt0[p], "rst_flush", 64'(resp_cnt[p]), 64'(cnt0[p]));
        p_req = 4'b1111;
        tick(gp);
        check(last_gnt == 4'b0001, "rst_ptr", 64'(last_gnt), 64'h1);
        drain();

        // Randomized traffic with held or dropped requests
        p_req = '0;
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < NP; p++) begin
                if (p_req[p]) begin
                    if ($urandom_range(0, 9) == 0) p_req[p] = 1'b0;
                end else if ($urandom_range(0, 9) < 4) begin
                    p_req[p]   = 1'b1;
                    p_we[p]    = 1'($urandom_range(0, 1));
                    p_addr[p]  = rand_addr();
                    p_wdata[p] = {$urandom, $urandom};
                    p_strb[p]  = 8'($urandom);
                end
            end
            tick(gp);
            if (gp >= 0) p_req[gp] = 1'b0;
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
